// File: rtl/frame_arbiter.sv
// rtl/frame_arbiter.sv - two-source whole-frame round-robin arbiter onto one byte sink
module frame_arbiter #(
    parameter int FRAME_LEN = 20,
    parameter int TIMEOUT   = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Avail0,
    input  logic       Avail1,
    input  logic [7:0] DataVal0,
    input  logic [7:0] DataVal1,
    input  logic       DataReady0,
    input  logic       DataReady1,
    output logic       DataNext0,
    output logic       DataNext1,
    output logic [7:0] OutVal,
    output logic       OutReady,
    input  logic       OutNext,
    output logic [1:0] Grant,
    output logic       Abort
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    localparam logic [7:0]  C_FRAME_LEN = 8'(FRAME_LEN);
    localparam logic [15:0] C_TMO_LAST  = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_pend;
    logic        r_outst;
    logic [7:0]  r_count;
    logic [15:0] r_timer;
    logic        r_last;
    logic [1:0]  r_grant;
    logic        r_next0;
    logic        r_next1;
    logic [7:0]  r_out_val;
    logic        r_out_ready;
    logic        r_abort;

    state_t      w_state_nxt;
    logic        w_pend_nxt;
    logic        w_outst_nxt;
    logic [7:0]  w_count_nxt;
    logic [15:0] w_timer_nxt;
    logic        w_last_nxt;
    logic [1:0]  w_grant_nxt;
    logic        w_next0_nxt;
    logic        w_next1_nxt;
    logic [7:0]  w_out_val_nxt;
    logic        w_out_ready_nxt;
    logic        w_abort_nxt;
    logic        w_sel;

    // Granted source index and its handshake lines; grant is one-hot so bit 1 names it.
    logic        w_g;
    logic        w_ready_g;
    logic [7:0]  w_val_g;
    logic        w_pend_eff;
    logic [7:0]  w_count_inc;

    assign w_g         = r_grant[1];
    assign w_ready_g   = w_g ? DataReady1 : DataReady0;
    assign w_val_g     = w_g ? DataVal1 : DataVal0;
    // A request arriving this cycle is merged with any held one, so it can be forwarded at once.
    assign w_pend_eff  = r_pend | OutNext;
    assign w_count_inc = r_count + 8'd1;

    assign DataNext0 = r_next0;
    assign DataNext1 = r_next1;
    assign OutVal    = r_out_val;
    assign OutReady  = r_out_ready;
    assign Grant     = r_grant;
    assign Abort     = r_abort;

    // State register: every control and output register updates from the next-state logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pend      <= 1'b0;
            r_outst     <= 1'b0;
            r_count     <= 8'd0;
            r_timer     <= 16'd0;
            r_last      <= 1'b1;
            r_grant     <= 2'b00;
            r_next0     <= 1'b0;
            r_next1     <= 1'b0;
            r_out_val   <= 8'd0;
            r_out_ready <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend      <= w_pend_nxt;
            r_outst     <= w_outst_nxt;
            r_count     <= w_count_nxt;
            r_timer     <= w_timer_nxt;
            r_last      <= w_last_nxt;
            r_grant     <= w_grant_nxt;
            r_next0     <= w_next0_nxt;
            r_next1     <= w_next1_nxt;
            r_out_val   <= w_out_val_nxt;
            r_out_ready <= w_out_ready_nxt;
            r_abort     <= w_abort_nxt;
        end
    end

    // Next-state logic: grant selection, request forwarding, byte return, frame end and watchdog.
    always_comb begin
        w_state_nxt     = r_state;
        w_pend_nxt      = w_pend_eff;
        w_outst_nxt     = r_outst;
        w_count_nxt     = r_count;
        w_timer_nxt     = r_timer;
        w_last_nxt      = r_last;
        w_grant_nxt     = r_grant;
        w_next0_nxt     = 1'b0;
        w_next1_nxt     = 1'b0;
        w_out_val_nxt   = r_out_val;
        w_out_ready_nxt = 1'b0;
        w_abort_nxt     = 1'b0;
        w_sel           = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (Avail0 | Avail1) begin
                    // On a tie the source that did not hold the last frame wins.
                    w_sel       = (Avail0 & Avail1) ? ~r_last : Avail1;
                    w_grant_nxt = w_sel ? 2'b10 : 2'b01;
                    w_count_nxt = 8'd0;
                    w_timer_nxt = 16'd0;
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (r_outst) begin
                    if (w_ready_g) begin
                        w_out_val_nxt   = w_val_g;
                        w_out_ready_nxt = 1'b1;
                        w_outst_nxt     = 1'b0;
                        w_count_nxt     = w_count_inc;
                        if (w_count_inc == C_FRAME_LEN) begin
                            w_last_nxt  = w_g;
                            w_grant_nxt = 2'b00;
                            w_state_nxt = S_IDLE;
                        end
                    end else if (r_timer == C_TMO_LAST) begin
                        // Source stalled: drop the grant but keep any held sink request.
                        w_abort_nxt = 1'b1;
                        w_outst_nxt = 1'b0;
                        w_last_nxt  = w_g;
                        w_grant_nxt = 2'b00;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_timer_nxt = r_timer + 16'd1;
                    end
                end else if (w_pend_eff) begin
                    w_next0_nxt = ~w_g;
                    w_next1_nxt = w_g;
                    w_pend_nxt  = 1'b0;
                    w_outst_nxt = 1'b1;
                    w_timer_nxt = 16'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_frame_arbiter.sv
// tb/tb_frame_arbiter.sv - randomized model-checked bench for frame_arbiter
module tb_frame_arbiter;

    localparam int FL  = 20;
    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       Avail0, Avail1;
    logic [7:0] DataVal0, DataVal1;
    logic       DataReady0, DataReady1;
    logic       DataNext0, DataNext1;
    logic [7:0] OutVal;
    logic       OutReady;
    logic       OutNext;
    logic [1:0] Grant;
    logic       Abort;

    frame_arbiter #(.FRAME_LEN(FL), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .Avail0(Avail0), .Avail1(Avail1),
        .DataVal0(DataVal0), .DataVal1(DataVal1),
        .DataReady0(DataReady0), .DataReady1(DataReady1),
        .DataNext0(DataNext0), .DataNext1(DataNext1),
        .OutVal(OutVal), .OutReady(OutReady), .OutNext(OutNext),
        .Grant(Grant), .Abort(Abort)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model (frame/owner/timestamp view) ----------------
    int         m_owner;   // -1 none, else source index
    int         m_bytes;
    int         m_last;
    int         m_req;     // cycle in which the forwarded request became visible
    bit         m_pend;
    bit         m_wait;
    int         mcyc = 0;
    logic       e_next0, e_next1, e_ready, e_abort;
    logic [7:0] e_val;
    logic [1:0] e_grant;

    task automatic model_reset();
        m_owner = -1; m_bytes = 0; m_last = 1; m_req = 0;
        m_pend = 0; m_wait = 0;
        e_next0 = 0; e_next1 = 0; e_ready = 0; e_abort = 0;
        e_val = 8'h00; e_grant = 2'b00;
    endtask

    // Inputs seen at this edge decide what the outputs must be for the next cycle.
    task automatic model_step();
        int  c;
        bit  pin;
        bit  r;
        c = mcyc;
        mcyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        e_next0 = 0; e_next1 = 0; e_ready = 0; e_abort = 0;
        pin = m_pend | OutNext;
        if (m_owner < 0) begin
            m_pend = pin;
            if (Avail0 || Avail1) begin
                if (Avail0 && Avail1) m_owner = (m_last == 0) ? 1 : 0;
                else                  m_owner = Avail0 ? 0 : 1;
                m_bytes = 0;
            end
        end else if (m_wait) begin
            m_pend = pin;
            r = (m_owner == 1) ? DataReady1 : DataReady0;
            if (r) begin
                e_ready = 1;
                e_val   = (m_owner == 1) ? DataVal1 : DataVal0;
                m_wait  = 0;
                m_bytes++;
                if (m_bytes == FL) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end else if (c - m_req == TMO - 1) begin
                e_abort = 1;
                m_wait  = 0;
                m_last  = m_owner;
                m_owner = -1;
            end
        end else if (pin) begin
            if (m_owner == 0) e_next0 = 1; else e_next1 = 1;
            m_pend = 0;
            m_wait = 1;
            m_req  = c + 1;
        end else begin
            m_pend = 0;
        end
        e_grant = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
    endtask

    // Single compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        check("cmp_next0",  32'(DataNext0), 32'(e_next0));
        check("cmp_next1",  32'(DataNext1), 32'(e_next1));
        check("cmp_ready",  32'(OutReady),  32'(e_ready));
        check("cmp_val",    32'(OutVal),    32'(e_val));
        check("cmp_grant",  32'(Grant),     32'(e_grant));
        check("cmp_abort",  32'(Abort),     32'(e_abort));
    end

    // ---------------- stimulus agents ----------------
    bit         auto_src [2];
    int         dmin [2];
    int         dmax [2];
    int         due [2];
    logic [7:0] seq [2];
    bit         auto_sink, rnd_sink, rnd_stray, rnd_avail;

    task automatic clear_stim();
        for (int s = 0; s < 2; s++) begin
            auto_src[s] = 0; dmin[s] = 1; dmax[s] = 1; due[s] = -1; seq[s] = 8'h00;
        end
        auto_sink = 0; rnd_sink = 0; rnd_stray = 0; rnd_avail = 0;
        Avail0 = 0; Avail1 = 0; OutNext = 0;
        DataReady0 = 0; DataReady1 = 0; DataVal0 = 8'h00; DataVal1 = 8'h00;
    endtask

    // One clock: model consumes the sampled inputs, then new inputs are driven 1 time unit later.
    task automatic tick();
        bit dn;
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        OutNext = 0; DataReady0 = 0; DataReady1 = 0;
        for (int s = 0; s < 2; s++) begin
            dn = (s == 0) ? DataNext0 : DataNext1;
            if (due[s] == cyc) begin
                if (s == 0) begin DataReady0 = 1; DataVal0 = seq[0]; end
                else        begin DataReady1 = 1; DataVal1 = seq[1]; end
                seq[s] = seq[s] + 8'd1;
                due[s] = -1;
            end
            if (auto_src[s] && dn) due[s] = cyc + int'($urandom_range(dmax[s], dmin[s]));
        end
        if (auto_sink && (OutReady || Abort)) OutNext = 1;
        if (rnd_sink && $urandom_range(3) == 0) OutNext = 1;
        if (rnd_stray) begin
            if (!DataReady0 && $urandom_range(15) == 0) begin DataReady0 = 1; DataVal0 = 8'($urandom); end
            if (!DataReady1 && $urandom_range(15) == 0) begin DataReady1 = 1; DataVal1 = 8'($urandom); end
        end
        if (rnd_avail) begin
            if ($urandom_range(15) == 0) Avail0 = ~Avail0;
            if ($urandom_range(15) == 0) Avail1 = ~Avail1;
        end
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_next0"}, 32'(DataNext0), 0);
        check({tag, "_next1"}, 32'(DataNext1), 0);
        check({tag, "_ready"}, 32'(OutReady), 0);
        check({tag, "_val"},   32'(OutVal), 0);
        check({tag, "_grant"}, 32'(Grant), 0);
        check({tag, "_abort"}, 32'(Abort), 0);
    endtask

    task automatic do_reset(string tag);
        rst_n = 0;
        model_reset();
        clear_stim();
        #1;
        check_all_zero(tag);
        tick();
        tick();
        rst_n = 1;
    endtask

    // Collects one frame from source 0 (bytes 0..FL-1), then withdraws Avail0.
    task automatic collect_frame(string tag);
        int         n;
        int         extra;
        logic [7:0] got [FL];
        n = 0;
        for (int b = 0; b < 800 && n < FL; b++) begin
            tick();
            if (OutReady) begin
                got[n] = OutVal;
                check({tag, "_grant_during"}, 32'(Grant), (n == FL - 1) ? 32'd0 : 32'd1);
                n++;
                if (n == FL) Avail0 = 0;
            end
        end
        check({tag, "_bytes"}, n, FL);
        for (int i = 0; i < n; i++) check({tag, "_byte"}, 32'(got[i]), i);
        extra = 0;
        repeat (6) begin
            tick();
            if (OutReady) extra++;
        end
        check({tag, "_extra_bytes"}, extra, 0);
        check({tag, "_grant_after"}, 32'(Grant), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int         found;
        int         ng;
        int         bad;
        int         nx;
        int         nr;
        int         na;
        logic [1:0] prevg;
        logic [1:0] gseq [4];

        rst_n = 1;
        model_reset();
        clear_stim();
        #1;
        do_reset("rst");

        // Single source, answers 2 cycles after each request.
        Avail0 = 1; auto_src[0] = 1; dmin[0] = 2; dmax[0] = 2; auto_sink = 1; OutNext = 1;
        collect_frame("single");

        // Round robin with both sources available.
        do_reset("rst_rr");
        Avail0 = 1; Avail1 = 1;
        auto_src[0] = 1; auto_src[1] = 1; dmin[0] = 1; dmax[0] = 5; dmin[1] = 1; dmax[1] = 5;
        auto_sink = 1; OutNext = 1;
        ng = 0; bad = 0; prevg = 2'b00;
        for (int b = 0; b < 2000 && ng < 4; b++) begin
            tick();
            if (Grant == 2'b01 && DataNext1) bad++;
            if (Grant != 2'b00 && prevg == 2'b00) begin gseq[ng] = Grant; ng++; end
            prevg = Grant;
        end
        check("rr_frames", ng, 4);
        check("rr_g0", 32'(gseq[0]), 32'h1);
        check("rr_g1", 32'(gseq[1]), 32'h2);
        check("rr_g2", 32'(gseq[2]), 32'h1);
        check("rr_next1_under_g01", bad, 0);

        // Latency of request forwarding and byte return.
        do_reset("rst_lat");
        Avail0 = 1;
        found = 0;
        for (int b = 0; b < 10 && found == 0; b++) begin
            tick();
            if (Grant == 2'b01) found = 1;
        end
        check("lat_granted", found, 1);
        tick(); OutNext = 1;
        check("lat_next_t", 32'(DataNext0), 0);
        tick();
        check("lat_next_t1", 32'(DataNext0), 1);
        check("lat_model_next", 32'(e_next0), 1);
        tick();
        check("lat_next_t2", 32'(DataNext0), 0);
        tick();
        tick(); DataReady0 = 1; DataVal0 = 8'hA5;
        check("lat_ready_u", 32'(OutReady), 0);
        tick();
        check("lat_ready_u1", 32'(OutReady), 1);
        check("lat_val_u1", 32'(OutVal), 32'hA5);
        check("lat_model_val", 32'(e_val), 32'hA5);

        // Watchdog: source 0 never answers; source 1 shows up meanwhile.
        do_reset("rst_wd");
        Avail0 = 1; OutNext = 1;
        found = 0;
        for (int b = 0; b < 10 && found == 0; b++) begin
            tick();
            if (DataNext0) found = 1;
        end
        check("wd_request_seen", found, 1);
        Avail1 = 1;
        bad = 0;
        repeat (TMO - 1) begin
            tick();
            if (Abort) bad++;
        end
        check("wd_abort_early", bad, 0);
        tick();
        check("wd_abort_pulse", 32'(Abort), 1);
        check("wd_grant_dropped", 32'(Grant), 0);
        check("wd_model_abort", 32'(e_abort), 1);
        tick();
        check("wd_abort_single", 32'(Abort), 0);
        check("wd_regrant_other", 32'(Grant), 32'h2);

        // Request merging in IDLE and stray DataReady from the other source.
        do_reset("rst_pend");
        OutNext = 1; tick(); tick();
        OutNext = 1; tick();
        OutNext = 1; tick();
        Avail0 = 1;
        nx = 0;
        tick();
        if (DataNext0 || DataNext1) nx++;
        check("pend_grant", 32'(Grant), 32'h1);
        tick();
        if (DataNext0 || DataNext1) nx++;
        DataReady1 = 1; DataVal1 = 8'h5A;
        tick();
        if (DataNext0 || DataNext1) nx++;
        check("stray_ignored", 32'(OutReady), 0);
        DataReady0 = 1; DataVal0 = 8'h3C;
        tick();
        if (DataNext0 || DataNext1) nx++;
        check("pend_byte_ready", 32'(OutReady), 1);
        check("pend_byte_val", 32'(OutVal), 32'h3C);
        repeat (6) begin
            tick();
            if (DataNext0 || DataNext1) nx++;
        end
        check("pend_single_next", nx, 1);

        // Reset in the middle of a frame, then a fresh full frame.
        do_reset("rst_mid0");
        Avail0 = 1; auto_src[0] = 1; dmin[0] = 2; dmax[0] = 2; auto_sink = 1; OutNext = 1;
        nr = 0;
        for (int b = 0; b < 300 && nr < 7; b++) begin
            tick();
            if (OutReady) nr++;
        end
        check("mid_bytes_before", nr, 7);
        do_reset("mid_rst");
        Avail0 = 1; auto_src[0] = 1; dmin[0] = 2; dmax[0] = 2; auto_sink = 1; OutNext = 1;
        collect_frame("after_rst");

        // Randomized traffic, including late answers that trip the watchdog.
        do_reset("rst_rand");
        auto_src[0] = 1; auto_src[1] = 1;
        dmin[0] = 1; dmax[0] = 10; dmin[1] = 1; dmax[1] = 10;
        auto_sink = 1; rnd_sink = 1; rnd_stray = 1; rnd_avail = 1;
        Avail0 = 1; Avail1 = 1; OutNext = 1;
        nr = 0; na = 0;
        repeat (4000) begin
            tick();
            if (OutReady) nr++;
            if (Abort) na++;
        end
        check("rand_progress", 32'(nr > 100), 1);
        check("rand_aborts_seen", 32'(na > 0), 1);
        clear_stim();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
